stm_idx_gen: RTL and testbench

STM_IDX_GEN -- requirements
Module: stm_idx_gen

---
 rtl/stm_idx_gen.sv | 75 +++++++
 tb/tb_stm_idx_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stm_idx_gen.sv
// Per-segment index generator: a prescaler divides CLK down to index steps and
// the index counts 0..cycle, wrapping with a one-cycle WRAP pulse.
module stm_idx_gen #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UPDATE_SETTINGS,
    input  logic [WIDTH-1:0] CYCLE    [2],
    input  logic [WIDTH-1:0] FREQ_DIV [2],
    input  logic             SYNC_SET,
    output logic [WIDTH-1:0] IDX_OUT  [2],
    output logic             WRAP     [2]
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cycle_q  [2];
    logic [WIDTH-1:0] div_q    [2];
    logic [WIDTH-1:0] cnt_q    [2];

    logic [WIDTH-1:0] cnt_nxt  [2];
    logic [WIDTH-1:0] idx_nxt  [2];
    logic             wrap_nxt [2];
    logic             step     [2];

    // div_q is never 0, so div_q-1 cannot underflow; the >= compares make a
    // freshly latched smaller cycle or divider take effect on the next step.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            step[s]     = (cnt_q[s] >= (div_q[s] - ONE));
            cnt_nxt[s]  = cnt_q[s] + ONE;
            idx_nxt[s]  = IDX_OUT[s];
            wrap_nxt[s] = 1'b0;
            if (step[s]) begin
                cnt_nxt[s] = '0;
                if (IDX_OUT[s] >= cycle_q[s]) begin
                    idx_nxt[s]  = '0;
                    wrap_nxt[s] = 1'b1;
                end else begin
                    idx_nxt[s] = IDX_OUT[s] + ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned s = 0; s < 2; s++) begin
                cycle_q[s] <= '0;
                div_q[s]   <= ONE;
                cnt_q[s]   <= '0;
                IDX_OUT[s] <= '0;
                WRAP[s]    <= 1'b0;
            end
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (UPDATE_SETTINGS) begin
                    cycle_q[s] <= CYCLE[s];
                    div_q[s]   <= (FREQ_DIV[s] == '0) ? ONE : FREQ_DIV[s];
                end
                if (SYNC_SET) begin
                    cnt_q[s]   <= '0;
                    IDX_OUT[s] <= '0;
                    WRAP[s]    <= 1'b0;
                end else begin
                    cnt_q[s]   <= cnt_nxt[s];
                    IDX_OUT[s] <= idx_nxt[s];
                    WRAP[s]    <= wrap_nxt[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_stm_idx_gen.sv
// Bench for stm_idx_gen: an age/hold model checked every cycle, plus directed
// sequences with hand-computed index and wrap patterns.
module tb_stm_idx_gen;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         upd;
    logic         sync;
    logic [W-1:0] cycle_in [2];
    logic [W-1:0] div_in   [2];
    logic [W-1:0] idx_out  [2];
    logic         wrap_out [2];

    int n_pass  = 0;
    int n_total = 0;

    stm_idx_gen #(.WIDTH(W)) dut (
        .CLK             (clk),
        .RST             (rst),
        .UPDATE_SETTINGS (upd),
        .CYCLE           (cycle_in),
        .FREQ_DIV        (div_in),
        .SYNC_SET        (sync),
        .IDX_OUT         (idx_out),
        .WRAP            (wrap_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: each index value is shown for div cycles (age counts cycles
    // already shown), then advances modulo cycle+1 with a wrap pulse.
    int  m_cyc  [2];
    int  m_div  [2];
    int  m_age  [2];
    int  m_idx  [2];
    int  m_wrap [2];
    bit  model_on = 1'b0;

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_cyc[s] = 0; m_div[s] = 1; m_age[s] = 0; m_idx[s] = 0; m_wrap[s] = 0;
            end else begin
                if (m_age[s] + 1 >= m_div[s]) begin
                    m_age[s]  = 0;
                    m_wrap[s] = (m_idx[s] >= m_cyc[s]) ? 1 : 0;
                    m_idx[s]  = (m_idx[s] >= m_cyc[s]) ? 0 : m_idx[s] + 1;
                end else begin
                    m_age[s]  = m_age[s] + 1;
                    m_wrap[s] = 0;
                end
                if (sync) begin
                    m_idx[s] = 0; m_age[s] = 0; m_wrap[s] = 0;
                end
                if (upd) begin
                    m_cyc[s] = int'(cycle_in[s]);
                    m_div[s] = (div_in[s] == '0) ? 1 : int'(div_in[s]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int s = 0; s < 2; s++) begin
                chk($sformatf("model_idx%0d", s), int'(idx_out[s]), m_idx[s]);
                chk($sformatf("model_wrap%0d", s), int'(wrap_out[s]), m_wrap[s]);
            end
        end
    end

    // Checks the values visible now and on the following negedges; an empty
    // queue skips that segment.
    task automatic sample2(input string name, input int i0[$], input int w0[$],
                           input int i1[$], input int w1[$]);
        int n;
        n = (i0.size() > i1.size()) ? i0.size() : i1.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (i < i0.size()) chk($sformatf("%s_idx0[%0d]", name, i), int'(idx_out[0]), i0[i]);
            if (i < w0.size()) chk($sformatf("%s_wrap0[%0d]", name, i), int'(wrap_out[0]), w0[i]);
            if (i < i1.size()) chk($sformatf("%s_idx1[%0d]", name, i), int'(idx_out[1]), i1[i]);
            if (i < w1.size()) chk($sformatf("%s_wrap1[%0d]", name, i), int'(wrap_out[1]), w1[i]);
        end
    endtask

    // Apply settings with UPDATE (and optionally SYNC) for one edge; returns at
    // the negedge after that edge with strobes low.
    task automatic apply(input int c0, input int d0, input int c1, input int d1, input bit s);
        @(negedge clk);
        cycle_in[0] = W'(c0); div_in[0] = W'(d0);
        cycle_in[1] = W'(c1); div_in[1] = W'(d1);
        upd = 1'b1; sync = s;
        @(negedge clk);
        upd = 1'b0; sync = 1'b0;
    endtask

    task automatic wait_idx(input string name, input int seg, input int val);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (int'(idx_out[seg]) == val) begin ok = 1'b1; break; end
        end
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: timeout waiting for idx%0d=%0d, got %0d", name, seg, val, idx_out[seg]);
    endtask

    int e[$];
    int z[$];

    initial begin
        rst = 1'b1; upd = 1'b0; sync = 1'b0;
        cycle_in[0] = '0; cycle_in[1] = '0; div_in[0] = '0; div_in[1] = '0;

        // Reset: two cycles high, then cycle=0/div=1 pulses WRAP every cycle.
        @(negedge clk);
        model_on = 1'b1;
        @(negedge clk);
        sample2("reset", '{0}, '{0}, '{0}, '{0});
        rst = 1'b0;
        @(negedge clk);
        sample2("post_reset", '{0,0,0}, '{1,1,1}, '{0,0,0}, '{1,1,1});

        // Basic stepping: cycle 3, div 2 on segment 0.
        apply(3, 2, 0, 1, 1'b1);
        sample2("basic", '{0,0,1,1,2,2,3,3,0,0,1}, '{0,0,0,0,0,0,0,0,1,0,0}, z, z);

        // Divider 0 treated as 1 on segment 1; segments independent.
        apply(1, 5, 4, 0, 1'b1);
        sample2("indep", '{0,0,0,0,0,1,1,1,1,1,0,0}, '{0,0,0,0,0,0,0,0,0,0,1,0},
                         '{0,1,2,3,4,0,1,2,3,4,0,1}, '{0,0,0,0,0,1,0,0,0,0,1,0});

        // Shrink cycle below the current index: wraps on the next step.
        apply(9, 3, 4, 0, 1'b1);
        wait_idx("shrink_wait", 0, 7);
        cycle_in[0] = W'(2); upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        sample2("shrink", '{7,7,0,0,0,1,1,1,2,2,2,0}, '{0,0,1,0,0,0,0,0,0,0,0,1}, z, z);

        // SYNC on the edge of a pending wrap step suppresses it.
        apply(3, 2, 4, 0, 1'b1);
        wait_idx("sync_wait", 0, 3);
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        sample2("sync_collide", '{0,0,1,1}, '{0,0,0,0}, z, z);

        // Shrink divider below cnt+1 on segment 1: steps on the next edge.
        apply(3, 2, 5, 8, 1'b1);
        repeat (5) @(negedge clk);
        div_in[1] = W'(2); upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        sample2("div_shrink", z, z, '{0,1,1,2,2}, '{0,0,0,0,0});

        // A few plain runs covered by the model only.
        apply(6, 1, 2, 3, 1'b0);
        repeat (40) @(negedge clk);
        apply(0, 4, 7, 1, 1'b0);
        repeat (40) @(negedge clk);

        // Reset mid-run beats SYNC and UPDATE on the same edge.
        @(negedge clk);
        cycle_in[0] = W'(7); div_in[0] = W'(3); cycle_in[1] = W'(7); div_in[1] = W'(3);
        rst = 1'b1; upd = 1'b1; sync = 1'b1;
        @(negedge clk);
        rst = 1'b0; upd = 1'b0; sync = 1'b0;
        sample2("mid_reset", '{0}, '{0}, '{0}, '{0});
        @(negedge clk);
        sample2("resume", '{0,0,0}, '{1,1,1}, '{0,0,0}, '{1,1,1});

        @(negedge clk);
        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
